// File: rtl/mux_rr_if.sv
// +----------------------------------------------------------------------+
// | mux_rr_if : requester/arbiter bundle for the shared 4:1 mux channel   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mux_rr_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       req;
  logic [3:0]       grant;
  logic             addr0;
  logic             addr1;
  logic             busy;
  logic [CNT_W-1:0] burst_cnt;

  modport master (
    output req,
    input  grant, addr0, addr1, busy, burst_cnt
  );

  modport slave (
    input  req,
    output grant, addr0, addr1, busy, burst_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | mux_rr_arbiter : round-robin owner selection with bounded bursts for  |
// | the shared 4:1 mux; registered grant, select lines and burst count.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  wire logic clk,
  input  wire logic reset_n,
  mux_rr_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       last_owner;
  logic [3:0]       grant_q;
  logic             addr0_q;
  logic             addr1_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       start_idx;
  logic [1:0]       scan_idx;
  logic             found;
  logic [1:0]       win;
  logic [3:0]       win_onehot;
  logic             handover;

  // Scan from the entry after the last owner; walking the offsets downward
  // lets the nearest requester overwrite any farther one.
  always_comb begin
    start_idx = last_owner + 2'd1;
    scan_idx  = start_idx;
    found     = 1'b0;
    win       = start_idx;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = start_idx + 2'(i);
      if (bus.req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    win_onehot = 4'b0001 << win;
    handover   = !bus.req[owner] || (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd3;
      grant_q    <= 4'b0000;
      addr0_q    <= 1'b0;
      addr1_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= OWN;
            owner      <= win;
            last_owner <= win;
            grant_q    <= win_onehot;
            addr0_q    <= win[0];
            addr1_q    <= win[1];
            busy_q     <= 1'b1;
            cnt_q      <= CNT_ONE;
          end
        end
        OWN: begin
          if (!handover) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else if (found) begin
            // Direct handover, no idle gap; the owner only wins again when alone.
            owner      <= win;
            last_owner <= win;
            grant_q    <= win_onehot;
            addr0_q    <= win[0];
            addr1_q    <= win[1];
            cnt_q      <= CNT_ONE;
          end else begin
            // Select lines keep their value so the mux output stays stable.
            state   <= IDLE;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 4'b0000;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.addr0     = addr0_q;
  assign bus.addr1     = addr1_q;
  assign bus.busy      = busy_q;
  assign bus.burst_cnt = cnt_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant_q));
  a_busy_grant : assert property (@(posedge clk) disable iff (!reset_n)
    busy_q == (|grant_q));
  a_addr_match : assert property (@(posedge clk) disable iff (!reset_n)
    busy_q |-> grant_q[{addr1_q, addr0_q}]);
  a_cnt_bound : assert property (@(posedge clk) disable iff (!reset_n)
    cnt_q <= CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mux_rr_arbiter : vector table + scoreboard bench for the arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mux_rr_if #(.CNT_W(4)) bus0 ();
  mux_rr_if #(.CNT_W(4)) bus1 ();

  mux_rr_arbiter #(.BURST_LEN(4), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  mux_rr_arbiter #(.BURST_LEN(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] addr;
    logic       busy;
    logic [3:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] a,
                              input logic b, input logic [3:0] c);
    exp_t e;
    e.grant = g; e.addr = a; e.busy = b; e.cnt = c;
    return e;
  endfunction

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] a,
                     input logic b, input logic [3:0] c);
    vec_t v;
    v.req = r;
    v.exp = mk(g, a, b, c);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pop_compare(input int sel, input string name);
    exp_t e;
    exp_t a;
    if (sel == 0) a = mk(bus0.grant, {bus0.addr1, bus0.addr0}, bus0.busy, bus0.burst_cnt);
    else          a = mk(bus1.grant, {bus1.addr1, bus1.addr0}, bus1.busy, bus1.burst_cnt);
    if (sb.size() == 0) begin
      check({name, ".scoreboard_empty"}, 16'd0, 16'd1);
      return;
    end
    e = sb.pop_front();
    check({name, ".grant"}, 16'(a.grant), 16'(e.grant));
    check({name, ".addr"},  16'(a.addr),  16'(e.addr));
    check({name, ".busy"},  16'(a.busy),  16'(e.busy));
    check({name, ".cnt"},   16'(a.cnt),   16'(e.cnt));
  endtask

  task automatic apply(input int sel, input logic [3:0] r, input exp_t e, input string name);
    @(negedge clk);
    if (sel == 0) bus0.req = r;
    else          bus1.req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare(sel, name);
  endtask

  always @(negedge clk) begin
    check("inv.onehot", 16'($onehot0(bus0.grant)), 16'd1);
    check("inv.busy",   16'(bus0.busy), 16'(|bus0.grant));
    if (bus0.busy)
      check("inv.addr", 16'(bus0.grant), 16'(4'b0001 << {bus0.addr1, bus0.addr0}));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [1:0] o;
    one = 4'b0001;
    bus0.req = 4'b0000;
    bus1.req = 4'b0000;

    // idle after reset
    repeat (3) add(4'b0000, 4'b0000, 2'b00, 1'b0, 4'd0);
    // sole requester 2: regranted every BURST_LEN cycles
    for (int i = 0; i < 10; i++) add(4'b0100, 4'b0100, 2'b10, 1'b1, 4'((i % 4) + 1));
    add(4'b0000, 4'b0000, 2'b10, 1'b0, 4'd0);
    add(4'b0000, 4'b0000, 2'b10, 1'b0, 4'd0);
    // all requesting, last owner 2: owners 3,0,1,2,3 with 4-cycle bursts
    for (int i = 0; i < 17; i++) begin
      o = 2'(3 + i / 4);
      add(4'b1111, one << o, o, 1'b1, 4'((i % 4) + 1));
    end
    // early release of owner 1 skips idle requester 2
    add(4'b0010, 4'b0010, 2'b01, 1'b1, 4'd1);
    add(4'b1010, 4'b0010, 2'b01, 1'b1, 4'd2);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd1);
    add(4'b0000, 4'b0000, 2'b11, 1'b0, 4'd0);
    // wrap-around priority from last owner 3
    add(4'b1001, 4'b0001, 2'b00, 1'b1, 4'd1);
    add(4'b0001, 4'b0001, 2'b00, 1'b1, 4'd2);
    add(4'b1001, 4'b0001, 2'b00, 1'b1, 4'd3);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd1);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd2);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd3);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd4);
    add(4'b1000, 4'b1000, 2'b11, 1'b1, 4'd1);
    add(4'b0000, 4'b0000, 2'b11, 1'b0, 4'd0);

    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(4'b0000, 2'b00, 1'b0, 4'd0));
    pop_compare(0, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(0, vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));

    // asynchronous reset in the middle of owner 2's burst
    apply(0, 4'b0100, mk(4'b0100, 2'b10, 1'b1, 4'd1), "mb1");
    apply(0, 4'b0100, mk(4'b0100, 2'b10, 1'b1, 4'd2), "mb2");
    apply(0, 4'b0100, mk(4'b0100, 2'b10, 1'b1, 4'd3), "mb3");
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back(mk(4'b0000, 2'b00, 1'b0, 4'd0));
    pop_compare(0, "async_rst");
    @(negedge clk);
    reset_n  = 1'b1;
    bus0.req = 4'b1111;
    sb.push_back(mk(4'b0001, 2'b00, 1'b1, 4'd1));
    @(posedge clk);
    #1;
    pop_compare(0, "post_rst");
    apply(0, 4'b1111, mk(4'b0001, 2'b00, 1'b1, 4'd2), "post_rst2");

    // BURST_LEN=1 rotates every cycle
    for (int i = 0; i < 6; i++) begin
      o = 2'(i);
      apply(1, 4'b1111, mk(one << o, o, 1'b1, 4'd1), $sformatf("bl1_rot%0d", i));
    end
    apply(1, 4'b0100, mk(4'b0100, 2'b10, 1'b1, 4'd1), "bl1_sole1");
    apply(1, 4'b0100, mk(4'b0100, 2'b10, 1'b1, 4'd1), "bl1_sole2");
    apply(1, 4'b0000, mk(4'b0000, 2'b10, 1'b0, 4'd0), "bl1_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 single-bit multiplexer.
- Four requesters compete for the mux output channel.
- The block picks one owner, drives the mux select lines (addr0, addr1) and a one-hot grant.
- It bounds each ownership to a burst of at most BURST_LEN cycles, so no requester can starve the others.

Parameters:
- BURST_LEN, 4, maximum consecutive cycles one requester may own the mux. Legal range 1..15.
- CNT_W, 4, width of the burst counter. Must hold BURST_LEN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; req[i] asks for mux input in_i.
- grant  output  4  one-hot ownership; all zero when idle.
- addr0  output  1  mux select LSB (owner index bit 0).
- addr1  output  1  mux select MSB (owner index bit 1).
- busy  output  1  high while a requester owns the mux.
- burst_cnt  output  CNT_W  cycles the current owner has held the grant, including the current cycle.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-burst):
  - grant=0000, addr0=0, addr1=0, busy=0, burst_cnt=0.
  - State=IDLE, last-owner pointer=3, so requester 0 has top priority first.
- All outputs are registered. There are no combinational paths from req to any output.
- Select encoding: owner index k gives addr1:addr0 = k[1]:k[0] and grant[k]=1. Examples: owner 1 gives addr0=1, addr1=0; owner 2 gives addr0=0, addr1=1.
- Priority search: scan req starting at index (last+1) mod 4 and wrap through 4 entries. The first set bit wins; call it W.
- States: IDLE and OWN.
- IDLE:
  - If req==0000, stay IDLE; outputs hold.
  - Else, at the next edge: state=OWN, owner=W, last=W, grant=onehot(W), addr set, busy=1, burst_cnt=1.
  - Latency: req sampled at edge N gives grant and addr valid after edge N (one-cycle latency).
- OWN, evaluated each edge; handover condition H = (req[owner]==0) or (burst_cnt==BURST_LEN):
  - H false: hold owner; burst_cnt increments.
  - H true and some req set (search from owner+1): switch directly to W in the same edge, with no idle gap; burst_cnt=1, last=W.
  - The current owner is regranted only if it is the sole requester. In that case burst_cnt restarts at 1.
  - H true and req==0000: go to IDLE. grant=0000, busy=0, burst_cnt=0. addr0/addr1 hold their last values so the mux output stays stable.
- A requester dropping req while not granted has no effect.
- Simultaneous release by the owner and a new request: the new request is served on that same edge.
- BURST_LEN=1: grant rotates every cycle among all active requesters.
- Invariants: grant is one-hot or zero; busy == |grant; addr matches the index of the set grant bit whenever busy=1.
- burst_cnt never exceeds BURST_LEN and never wraps.

Test Plan:
- Reset, then req=0000 for 5 cycles → grant=0000, busy=0, addr0=0, addr1=0, burst_cnt=0 throughout.
- Single requester: req=0100 held for 10 cycles, BURST_LEN=4 → grant=0100 and addr1=1, addr0=0 every cycle. burst_cnt runs 1,2,3,4,1,2,… (sole-requester regrant). Drop req → IDLE next edge, addr holds at 1:0.
- All requesting: req=1111, BURST_LEN=4 → owners 0,1,2,3,0 with each owner held exactly 4 cycles. addr1:addr0 sequence 00,01,10,11. No idle cycle between owners.
- Early release: owner 1 drops req at burst_cnt=2 while req[3]=1 → next edge grant=1000, addr=11, burst_cnt=1. Requester 2 is skipped because it is not requesting.
- Reset mid-burst: assert reset_n=0 asynchronously (mid-cycle) while owner 2 is at burst_cnt=3 → outputs clear immediately. After release with req=1111, the first grant goes to requester 0.
- Wrap-around priority: last=3, req=1001 → grant 0001, not 1000. Then requester 0 releases with req=1000 → grant 1000.
